// File: rtl/dlx_pkg.sv
// Shared DLX definitions: ALU op codes, op type and the EX/MEM register layout.
// Used by the control decoder, the ALU and the execute stage.
package dlx_pkg;

  typedef logic [4:0] alu_op_t;

  localparam alu_op_t ALU_ADD   = 5'd0;
  localparam alu_op_t ALU_ADDU  = 5'd1;
  localparam alu_op_t ALU_SUB   = 5'd2;
  localparam alu_op_t ALU_SUBU  = 5'd3;
  localparam alu_op_t ALU_AND   = 5'd4;
  localparam alu_op_t ALU_OR    = 5'd5;
  localparam alu_op_t ALU_XOR   = 5'd6;
  localparam alu_op_t ALU_LHI   = 5'd7;
  localparam alu_op_t ALU_SLL   = 5'd8;
  localparam alu_op_t ALU_SRL   = 5'd9;
  localparam alu_op_t ALU_SRA   = 5'd10;
  localparam alu_op_t ALU_SEQ   = 5'd11;
  localparam alu_op_t ALU_SNE   = 5'd12;
  localparam alu_op_t ALU_SLT   = 5'd13;
  localparam alu_op_t ALU_SGT   = 5'd14;
  localparam alu_op_t ALU_SLE   = 5'd15;
  localparam alu_op_t ALU_SGE   = 5'd16;
  localparam alu_op_t ALU_SLTU  = 5'd17;
  localparam alu_op_t ALU_SGTU  = 5'd18;
  localparam alu_op_t ALU_PASSA = 5'd19;

  typedef struct packed {
    logic [31:0] result;
    logic        memtoreg;
    logic        regwrite;
    logic        memwrite;
    logic [4:0]  towrite;
    logic [31:0] mem_data;
  } exmem_t;

endpackage

// File: rtl/dlx_alu.sv
// Combinational DLX ALU: result plus carry/overflow/zero/set flags.
// Shifts (ops 8-10) exist only when DLX_EX_SHIFTER_EN is defined; otherwise they yield 0.
module dlx_alu
  import dlx_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_t     op_i,
  output logic [31:0] result_o,
  output logic        carry_o,
  output logic        overflow_o,
  output logic        zero_o,
  output logic        set_o
);

  logic [32:0] add_w;
  logic [32:0] sub_w;
  logic        slt_w;
  logic        sltu_w;
  logic        set_bit;
  logic        is_set;

  // Subtraction as A + ~B + 1, so the carry out reads as "no borrow".
  assign add_w  = {1'b0, a_i} + {1'b0, b_i};
  assign sub_w  = {1'b0, a_i} + {1'b0, ~b_i} + 33'd1;
  assign slt_w  = $signed(a_i) < $signed(b_i);
  assign sltu_w = a_i < b_i;

  always_comb begin
    result_o   = '0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    set_bit    = 1'b0;
    is_set     = 1'b0;
    case (op_i)
      ALU_ADD: begin
        result_o   = add_w[31:0];
        carry_o    = add_w[32];
        overflow_o = (a_i[31] == b_i[31]) && (add_w[31] != a_i[31]);
      end
      ALU_ADDU: begin
        result_o = add_w[31:0];
        carry_o  = add_w[32];
      end
      ALU_SUB: begin
        result_o   = sub_w[31:0];
        carry_o    = sub_w[32];
        overflow_o = (a_i[31] != b_i[31]) && (sub_w[31] != a_i[31]);
      end
      ALU_SUBU: begin
        result_o = sub_w[31:0];
        carry_o  = sub_w[32];
      end
      ALU_AND:   result_o = a_i & b_i;
      ALU_OR:    result_o = a_i | b_i;
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_LHI:   result_o = {b_i[15:0], 16'h0000};
`ifdef DLX_EX_SHIFTER_EN
      ALU_SLL:   result_o = a_i << b_i[4:0];
      ALU_SRL:   result_o = a_i >> b_i[4:0];
      ALU_SRA:   result_o = 32'($signed(a_i) >>> b_i[4:0]);
`else
      ALU_SLL, ALU_SRL, ALU_SRA: result_o = '0;
`endif
      ALU_SEQ:   begin is_set = 1'b1; set_bit = (a_i == b_i);        end
      ALU_SNE:   begin is_set = 1'b1; set_bit = (a_i != b_i);        end
      ALU_SLT:   begin is_set = 1'b1; set_bit = slt_w;               end
      ALU_SGT:   begin is_set = 1'b1; set_bit = !slt_w && (a_i != b_i); end
      ALU_SLE:   begin is_set = 1'b1; set_bit = slt_w || (a_i == b_i); end
      ALU_SGE:   begin is_set = 1'b1; set_bit = !slt_w;              end
      ALU_SLTU:  begin is_set = 1'b1; set_bit = sltu_w;              end
      ALU_SGTU:  begin is_set = 1'b1; set_bit = !sltu_w && (a_i != b_i); end
      ALU_PASSA: result_o = a_i;
      default:   result_o = '0;
    endcase
    if (is_set) result_o = {31'd0, set_bit};
  end

  assign set_o  = is_set & set_bit;
  assign zero_o = (result_o == 32'd0);

endmodule

// File: rtl/dlx_ex_stage.sv
// DLX execute stage: combinational ALU plus the falling-edge EX/MEM pipeline register.
// Barrel shifter support is selected by DLX_EX_SHIFTER_EN (see dlx_alu).
module dlx_ex_stage
  import dlx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  Op_ex,
  input  logic        MemtoReg_ex,
  input  logic        RegWrite_ex,
  input  logic        MemWrite_ex,
  input  logic [4:0]  towrite,
  input  logic [31:0] mem_data,
  output logic [31:0] Result_ex,
  output logic        Carryout,
  output logic        Overflow,
  output logic        Zero,
  output logic        Set,
  output logic [31:0] Result_mem,
  output logic        MemtoReg_mem,
  output logic        RegWrite_mem,
  output logic        MemWrite_mem,
  output logic [4:0]  towrite_ex,
  output logic [31:0] mem_data_ex
);

  exmem_t exmem_d;
  exmem_t exmem_q;

  dlx_alu u_alu (
    .a_i        (A),
    .b_i        (B),
    .op_i       (Op_ex),
    .result_o   (Result_ex),
    .carry_o    (Carryout),
    .overflow_o (Overflow),
    .zero_o     (Zero),
    .set_o      (Set)
  );

  assign exmem_d = '{
    result:   Result_ex,
    memtoreg: MemtoReg_ex,
    regwrite: RegWrite_ex,
    memwrite: MemWrite_ex,
    towrite:  towrite,
    mem_data: mem_data
  };

  // Interstage registers in this CPU all capture on the falling edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) exmem_q <= '0;
    else        exmem_q <= exmem_d;
  end

  assign Result_mem   = exmem_q.result;
  assign MemtoReg_mem = exmem_q.memtoreg;
  assign RegWrite_mem = exmem_q.regwrite;
  assign MemWrite_mem = exmem_q.memwrite;
  assign towrite_ex   = exmem_q.towrite;
  assign mem_data_ex  = exmem_q.mem_data;

endmodule

// File: tb/tb_dlx_ex_stage.sv
// Scoreboard bench for dlx_ex_stage: randomized ops checked against an arithmetic reference model.
module tb_dlx_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B, mem_data;
  logic [4:0]  Op_ex, towrite;
  logic        MemtoReg_ex, RegWrite_ex, MemWrite_ex;
  logic [31:0] Result_ex, Result_mem, mem_data_ex;
  logic        Carryout, Overflow, Zero, Set;
  logic        MemtoReg_mem, RegWrite_mem, MemWrite_mem;
  logic [4:0]  towrite_ex;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [31:0] res;
    logic        c, v, z, s;
    logic        mtr, rw, mw;
    logic [4:0]  tw;
    logic [31:0] md;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  dlx_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Op_ex(Op_ex),
    .MemtoReg_ex(MemtoReg_ex), .RegWrite_ex(RegWrite_ex), .MemWrite_ex(MemWrite_ex),
    .towrite(towrite), .mem_data(mem_data),
    .Result_ex(Result_ex), .Carryout(Carryout), .Overflow(Overflow), .Zero(Zero), .Set(Set),
    .Result_mem(Result_mem), .MemtoReg_mem(MemtoReg_mem), .RegWrite_mem(RegWrite_mem),
    .MemWrite_mem(MemWrite_mem), .towrite_ex(towrite_ex), .mem_data_ex(mem_data_ex)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  // Reference: results from plain integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, sr;
    longint unsigned ua, ub, ur;
    logic is_set, sbit;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    is_set = 1'b0;
    sbit = 1'b0;
    e.op = op; e.a = a; e.b = b;
    e.res = 32'd0; e.c = 1'b0; e.v = 1'b0;
    case (op)
      0, 1: begin
        ur = ua + ub;
        sr = sa + sb;
        e.res = ur[31:0];
        e.c = (ur > 64'hFFFF_FFFF);
        e.v = (op == 0) && (sr > SMAX || sr < SMIN);
      end
      2, 3: begin
        sr = sa - sb;
        e.res = a - b;
        e.c = (ua >= ub);
        e.v = (op == 2) && (sr > SMAX || sr < SMIN);
      end
      4: e.res = a & b;
      5: e.res = a | b;
      6: e.res = a ^ b;
      7: e.res = b * 32'd65536;
`ifdef DLX_EX_SHIFTER_EN
      8:  e.res = 32'(ua * (64'd1 << b[4:0]));
      9:  e.res = 32'(ua / (64'd1 << b[4:0]));
      10: begin
        sr = sa;
        for (int i = 0; i < int'(b[4:0]); i++) sr = (sr < 0) ? ((sr - 1) / 2) : (sr / 2);
        e.res = 32'(sr);
      end
`endif
      11: begin is_set = 1; sbit = (a == b);   end
      12: begin is_set = 1; sbit = (a != b);   end
      13: begin is_set = 1; sbit = (sa < sb);  end
      14: begin is_set = 1; sbit = (sa > sb);  end
      15: begin is_set = 1; sbit = (sa <= sb); end
      16: begin is_set = 1; sbit = (sa >= sb); end
      17: begin is_set = 1; sbit = (ua < ub);  end
      18: begin is_set = 1; sbit = (ua > ub);  end
      19: e.res = a;
      default: e.res = 32'd0;
    endcase
    if (is_set) e.res = sbit ? 32'd1 : 32'd0;
    e.s = is_set && sbit;
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic mtr, input logic rw, input logic mw,
                       input logic [4:0] tw, input logic [31:0] md);
    exp_t e;
    @(posedge clk);
    Op_ex = op; A = a; B = b; MemtoReg_ex = mtr; RegWrite_ex = rw; MemWrite_ex = mw;
    towrite = tw; mem_data = md;
    e = model(op, a, b);
    e.mtr = mtr; e.rw = rw; e.mw = mw; e.tw = tw; e.md = md;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] rword();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000 - 32'($urandom_range(0, 1));
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: the register captures on the falling edge, so comb and registered
  // outputs for one transaction are both visible just after it.
  initial begin : monitor
    exp_t e, last;
    bit have_last;
    have_last = 0;
    forever begin
      @(negedge clk); #1;
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        $display("txn op=%0d a=%h b=%h res=%h c%0b v%0b z%0b s%0b", e.op, e.a, e.b,
                 Result_ex, Carryout, Overflow, Zero, Set);
        chk("result_ex", Result_ex, e.res);
        chk("carryout", 32'(Carryout), 32'(e.c));
        chk("overflow", 32'(Overflow), 32'(e.v));
        chk("zero", 32'(Zero), 32'(e.z));
        chk("set", 32'(Set), 32'(e.s));
        chk("result_mem", Result_mem, e.res);
        chk("memtoreg_mem", 32'(MemtoReg_mem), 32'(e.mtr));
        chk("regwrite_mem", 32'(RegWrite_mem), 32'(e.rw));
        chk("memwrite_mem", 32'(MemWrite_mem), 32'(e.mw));
        chk("towrite_ex", 32'(towrite_ex), 32'(e.tw));
        chk("mem_data_ex", mem_data_ex, e.md);
        last = e;
        have_last = 1;
      end else begin
        have_last = 0;
      end
      @(posedge clk); #1;
      if (have_last) begin
        chk("hold_result_mem", Result_mem, last.res);
        chk("hold_regwrite_mem", 32'(RegWrite_mem), 32'(last.rw));
        chk("hold_towrite_ex", 32'(towrite_ex), 32'(last.tw));
        chk("hold_mem_data_ex", mem_data_ex, last.md);
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0;
    Op_ex = 5'd0; A = 32'd1; B = 32'd2;
    MemtoReg_ex = 1'b1; RegWrite_ex = 1'b1; MemWrite_ex = 1'b1;
    towrite = 5'd3; mem_data = 32'd5;
    #3;
    chk("rst_result_mem", Result_mem, 32'd0);
    chk("rst_regwrite_mem", 32'(RegWrite_mem), 32'd0);
    #9;
    chk("rst_hold_regwrite", 32'(RegWrite_mem), 32'd0);
    chk("rst_hold_memwrite", 32'(MemWrite_mem), 32'd0);
    chk("rst_hold_towrite", 32'(towrite_ex), 32'd0);
    chk("rst_comb_result", Result_ex, 32'd3);
    #1 rst_n = 1'b1;

    issue(5'd0,  32'h7FFF_FFFF, 32'd1, 0, 1, 0, 5'd1, 32'd0);
    issue(5'd2,  32'd5, 32'd5, 0, 1, 0, 5'd2, 32'd0);
    issue(5'd3,  32'd5, 32'd5, 0, 1, 0, 5'd2, 32'd0);
    issue(5'd13, 32'hFFFF_FFFF, 32'd1, 0, 1, 0, 5'd4, 32'd0);
    issue(5'd17, 32'hFFFF_FFFF, 32'd1, 0, 1, 0, 5'd4, 32'd0);
    issue(5'd10, 32'h8000_0000, 32'd4, 0, 1, 0, 5'd5, 32'd0);
    issue(5'd7,  32'd0, 32'h1234, 0, 1, 0, 5'd6, 32'd0);
    issue(5'd1,  32'hFFFF_FFFF, 32'd1, 1, 1, 1, 5'd7, 32'hDEAD_BEEF);
    issue(5'd2,  32'h8000_0000, 32'd1, 0, 0, 0, 5'd0, 32'd0);
    issue(5'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 5'd31, 32'd1);
    for (int i = 0; i < 300; i++)
      issue(5'($urandom_range(0, 23)), rword(), rword(), 1'($urandom), 1'($urandom),
            1'($urandom), 5'($urandom), $urandom);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);

    // Asynchronous reset between edges discards the in-flight instruction.
    @(posedge clk);
    Op_ex = 5'd0; A = 32'd10; B = 32'd20; MemtoReg_ex = 1'b0;
    RegWrite_ex = 1'b1; MemWrite_ex = 1'b1; towrite = 5'd9; mem_data = 32'h1234_5678;
    @(negedge clk); #2;
    chk("pre_rst_regwrite", 32'(RegWrite_mem), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_regwrite", 32'(RegWrite_mem), 32'd0);
    chk("async_rst_memwrite", 32'(MemWrite_mem), 32'd0);
    chk("async_rst_result", Result_mem, 32'd0);
    chk("async_rst_towrite", 32'(towrite_ex), 32'd0);
    chk("rst_comb_follow", Result_ex, 32'd30);
    @(posedge clk);
    A = 32'd40;
    #2 rst_n = 1'b1;
    #1;
    chk("release_no_capture", 32'(RegWrite_mem), 32'd0);
    @(negedge clk); #1;
    chk("resume_result", Result_mem, 32'd60);
    chk("resume_regwrite", 32'(RegWrite_mem), 32'd1);
    chk("resume_towrite", 32'(towrite_ex), 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
